// File: rtl/enc_pkg.sv
// Shared types and helpers for the mask-to-index encoder.
// Holds the FSM state encoding and the index-width derivation.
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mask_index_encoder_lsb_find.sv
// Combinational priority search: index of the lowest set bit of a vector,
// plus flags for "any bit set" and "at most one bit set".
module lsb_find
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any,
    output logic         o_single
);

    logic [N-1:0] w_clr_low;

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = W'(i);
        end
    end

    assign w_clr_low = i_vec & (i_vec - N'(1));
    assign o_any     = |i_vec;
    assign o_single  = (w_clr_low == '0);

endmodule

// File: rtl/mask_index_encoder.sv
// Serialises a request mask into one binary index per output beat, lowest
// set bit first; an all-zero mask yields a single beat flagged out_none.
module mask_index_encoder
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
);

    state_t       r_state;
    logic [N-1:0] r_rem;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_single;
    logic         w_emit;

    lsb_find #(.N(N)) u_lsb_find (
        .i_vec    (r_rem),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_single (w_single)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rem   <= in_mask;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_rem <= r_rem & (r_rem - N'(1));
                        if (w_single) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs come only from rem/state, never from the input side.
    assign w_emit    = (r_state == EMIT);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = w_emit;
    assign out_idx   = w_idx;
    assign out_last  = w_emit && w_single;
    assign out_none  = w_emit && !w_any;

endmodule

// File: tb/tb_mask_index_encoder.sv
// Randomised self-checking bench for mask_index_encoder against a
// bit-list reference model of the expected beat sequence.
module tb_mask_index_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;

    int n_tests;
    int n_fail;

    mask_index_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one mask and checks every beat. mode: 0 ready always, 1 toggle
    // starting high, 2 random. If hold is set, in_valid stays high with
    // next_mask during EMIT to show it is ignored until IDLE.
    task automatic run_mask(input logic [N-1:0] m, input int mode,
                            input bit hold, input logic [N-1:0] next_mask,
                            input string name);
        int exp_q[$];
        int nb;
        int bi;
        int cyc;
        bit rdy;
        exp_q = {};
        for (int b = 0; b < N; b++) if (m[b]) exp_q.push_back(b);
        if (exp_q.size() == 0) exp_q.push_back(0);
        nb = exp_q.size();

        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_mask  = m;
        tick();
        if (hold) in_mask = next_mask;
        else      in_valid = 1'b0;

        bi = 0;
        cyc = 0;
        while (bi < nb && cyc < 64) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_idx !== W'(exp_q[bi]) || out_last !== (bi == nb - 1) ||
                out_none !== (m == '0)) begin
                n_fail++;
                $display("FAIL %s beat%0d: got v=%b r=%b idx=%0d last=%b none=%b want v=1 r=0 idx=%0d last=%b none=%b",
                         name, bi, out_valid, in_ready, out_idx, out_last, out_none,
                         exp_q[bi], (bi == nb - 1), (m == '0));
            end
            tick();
            cyc++;
            if (rdy) bi++;
        end
        out_ready = 1'b0;
        if (bi < nb) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, bi, nb);
        end
        if (mode == 0) begin
            n_tests++;
            if (cyc != nb) begin
                n_fail++;
                $display("FAIL %s occupancy: got %0d want %0d", name, cyc + 1, nb + 1);
            end
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_last: got ready=%b valid=%b want ready=1 valid=0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0 ||
            out_last !== 1'b0 || out_none !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got r=%b v=%b idx=%0d last=%b none=%b want 1 0 0 0 0",
                     in_ready, out_valid, out_idx, out_last, out_none);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        run_mask(8'b0010_0100, 0, 1'b0, '0, "two_bits");
        run_mask(8'h00, 0, 1'b0, '0, "zero_mask");
        run_mask(8'hFF, 1, 1'b0, '0, "all_ones_stall");
        run_mask(8'b1000_0000, 0, 1'b1, 8'h3C, "top_bit_hold");
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_mask  = 8'h0F;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_idx !== W'(k)) begin
                n_fail++;
                $display("FAIL mid_reset_pre%0d: got v=%b idx=%0d want v=1 idx=%0d",
                         k, out_valid, out_idx, k);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_reset_post%0d: got v=%b r=%b want v=0 r=1",
                         k, out_valid, in_ready);
            end
            tick();
        end
        out_ready = 1'b0;
        run_mask(8'h10, 0, 1'b0, '0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_mask(8'h01, 0, 1'b1, 8'h80, "b2b_first");
        run_mask(8'h80, 0, 1'b0, '0, "b2b_second");
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        for (int t = 0; t < 40; t++) begin
            m = N'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            run_mask(m, 2, 1'b0, '0, "random");
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
